noc_pkt_tx: RTL and testbench

Packetiser on the read side of the byte `fifo`. It drains buffered bytes into NoC packets: one header flit carrying destination and length, then payload flits. Output is a valid/ready flit link into the router injection port. A packet starts when a full maximum-length packet is buffered, or when a partial packet has waited past an idle timeout.

---
 rtl/noc_pkt_tx.sv | 169 ++++++++++++++++
 tb/tb_noc_pkt_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_pkt_tx.sv
// noc_pkt_tx: packetiser on the read side of a first-word-fall-through byte FIFO.
// Emits one header flit {01, dest, len-1} followed by len payload flits taken
// straight from the FIFO head. A packet starts once MAXLEN bytes are buffered,
// or once a partial packet has sat idle for (1<<LGTIMEOUT) cycles.
// Optional build macro NOC_PKT_CSUM_EN appends a {11, xor-checksum} tail flit
// (payload flits are then all BODY); without it the last payload flit is TAIL.
//
// state | meaning
// IDLE  | waiting for a full packet or for the idle timeout
// HEAD  | presenting the header flit
// BODY  | forwarding payload bytes from the FIFO head
// CSUM  | presenting the checksum tail flit (NOC_PKT_CSUM_EN only)
module noc_pkt_tx #(
  parameter int BW        = 8,
  parameter int LGFLEN    = 4,
  parameter int DW        = 4,
  parameter int LGMAXLEN  = 4,
  parameter int LGTIMEOUT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DW-1:0]     i_dest,
  input  logic              i_fifo_empty,
  input  logic [LGFLEN:0]   i_fifo_fill,
  input  logic [BW-1:0]     i_fifo_data,
  output logic              o_fifo_rd,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [BW+1:0]     o_flit,
  output logic              o_busy
);

  localparam logic [LGFLEN:0]      MAXLEN_F = (LGFLEN+1)'(1 << LGMAXLEN);
  localparam logic [LGMAXLEN:0]    MAXLEN_L = (LGMAXLEN+1)'(1 << LGMAXLEN);
  localparam logic [LGMAXLEN:0]    ONE_L    = 1;
  localparam logic [LGMAXLEN-1:0]  ONE_M    = 1;
  localparam logic [LGTIMEOUT-1:0] ONE_T    = 1;
  localparam logic [LGTIMEOUT-1:0] IDLE_MAX = '1;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
`ifdef NOC_PKT_CSUM_EN
    S_BODY = 2'd2,
    S_CSUM = 2'd3
`else
    S_BODY = 2'd2
`endif
  } state_t;

  state_t                state, state_nxt;
  logic [LGTIMEOUT-1:0]  idle_cnt;
  logic [LGMAXLEN:0]     len;
  logic [LGMAXLEN:0]     remaining;
  logic [DW-1:0]         dest;
  logic                  fill_lt_max;
  logic                  start;
  logic                  hs;
  logic                  last_byte;
  logic [LGMAXLEN:0]     len_start;
  logic [LGMAXLEN-1:0]   len_m1;
  logic [BW-1:0]         head_data;
  logic [1:0]            body_type;

  assign fill_lt_max = (i_fifo_fill < MAXLEN_F);
  assign start       = !fill_lt_max || ((i_fifo_fill != '0) && (idle_cnt == IDLE_MAX));
  assign len_start   = fill_lt_max ? i_fifo_fill[LGMAXLEN:0] : MAXLEN_L;
  assign len_m1      = len[LGMAXLEN-1:0] - ONE_M;
  assign head_data   = {dest, len_m1};
  assign hs          = o_valid && i_ready;
  assign last_byte   = (remaining == ONE_L);

`ifdef NOC_PKT_CSUM_EN
  logic [BW-1:0] csum;
  assign body_type = T_BODY;

  // checksum accumulates header data then every accepted payload byte
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      csum <= '0;
    end else if (state == S_HEAD && hs) begin
      csum <= head_data;
    end else if (state == S_BODY && hs) begin
      csum <= csum ^ i_fifo_data;
    end
  end
`else
  assign body_type = last_byte ? T_TAIL : T_BODY;
`endif

  // state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // packet bookkeeping: idle timer, latched length/destination, payload countdown
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idle_cnt  <= '0;
      len       <= '0;
      remaining <= '0;
      dest      <= '0;
    end else begin
      if (state == S_IDLE && !start) begin
        if (i_fifo_fill == '0)
          idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX)
          idle_cnt <= idle_cnt + ONE_T;
      end else begin
        idle_cnt <= '0;
      end
      if (state == S_IDLE && start) begin
        len  <= len_start;
        dest <= i_dest;
      end
      if (state == S_HEAD && hs)
        remaining <= len;
      else if (state == S_BODY && hs)
        remaining <= remaining - ONE_L;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_HEAD;
      S_HEAD: if (hs) state_nxt = S_BODY;
`ifdef NOC_PKT_CSUM_EN
      S_BODY: if (hs && last_byte) state_nxt = S_CSUM;
      S_CSUM: if (hs) state_nxt = S_IDLE;
`else
      S_BODY: if (hs && last_byte) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // flit link outputs; FIFO pop is the only path from i_ready
  always_comb begin
    o_valid   = 1'b0;
    o_flit    = '0;
    o_fifo_rd = 1'b0;
    o_busy    = (state != S_IDLE);
    case (state)
      S_HEAD: begin
        o_valid = 1'b1;
        o_flit  = {T_HEAD, head_data};
      end
      S_BODY: begin
        o_valid   = !i_fifo_empty;
        o_flit    = {body_type, i_fifo_data};
        o_fifo_rd = !i_fifo_empty && i_ready;
      end
`ifdef NOC_PKT_CSUM_EN
      S_CSUM: begin
        o_valid = 1'b1;
        o_flit  = {T_TAIL, csum};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_noc_pkt_tx.sv
// Bench for noc_pkt_tx: behavioural FWFT FIFO, flit scoreboard, table of packets
// plus hand-written mid-packet reset and oversupply sequences.
`timescale 1ns/1ps
module tb_noc_pkt_tx;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [3:0] i_dest = 4'h0;
  logic       i_fifo_empty = 1'b1;
  logic [4:0] i_fifo_fill = 5'd0;
  logic [7:0] i_fifo_data = 8'h00;
  logic       o_fifo_rd;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic [9:0] o_flit;
  logic       o_busy;

  noc_pkt_tx dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_dest(i_dest),
    .i_fifo_empty(i_fifo_empty), .i_fifo_fill(i_fifo_fill), .i_fifo_data(i_fifo_data),
    .o_fifo_rd(o_fifo_rd), .o_valid(o_valid), .i_ready(i_ready),
    .o_flit(o_flit), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: first-word-fall-through, no reset, pops on o_fifo_rd
  logic [7:0] fq[$];
  logic [7:0] pend[$];
  always @(posedge i_clk) begin
    if (o_fifo_rd && fq.size() > 0) fq.delete(0);
    while (pend.size() > 0) fq.push_back(pend.pop_front());
    i_fifo_fill  <= 5'(fq.size());
    i_fifo_empty <= (fq.size() == 0);
    i_fifo_data  <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  // ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random
  int rmode = 0;
  int rph = 0;
  always @(posedge i_clk) begin
    #1;
    case (rmode)
      0: i_ready = 1'b1;
      1: begin i_ready = ((rph % 4) == 0) || ((rph % 4) == 3); rph++; end
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // scoreboard monitor, sampled on the falling edge
  logic [9:0] exp_q[$];
  int rd_cnt = 0;
  int hs_cnt = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [9:0] pf = '0;
  always @(negedge i_clk) begin
    if (i_reset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) check("stall_hold", {o_valid, o_flit}, {1'b1, pf});
      if (o_fifo_rd) begin
        rd_cnt++;
        check("rd_only_on_hs", {o_valid, i_ready, i_fifo_empty}, 3'b110);
      end
      if (o_valid && i_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_flit: got %0h want none at %0t", o_flit, $time);
        end else begin
          check("flit", o_flit, exp_q.pop_front());
        end
      end
      pv = o_valid; pr = i_ready; pf = o_flit;
    end
  end

  typedef struct {
    logic [3:0] dest;
    int         n;
    logic [7:0] base;
    logic [7:0] step;
    int         mode;
    logic [9:0] exp_head;
  } vec_t;

  vec_t vecs[6];

  function automatic int nflits(input int n);
`ifdef NOC_PKT_CSUM_EN
    return n + 2;
`else
    return n + 1;
`endif
  endfunction

  task automatic build_exp(input logic [9:0] head, input int n, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] b;
`ifdef NOC_PKT_CSUM_EN
    logic [7:0] cs;
    cs = head[7:0];
`endif
    exp_q.push_back(head);
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i) * step;
`ifdef NOC_PKT_CSUM_EN
      cs ^= b;
      exp_q.push_back({2'b00, b});
`else
      exp_q.push_back({(i == n - 1) ? 2'b11 : 2'b00, b});
`endif
    end
`ifdef NOC_PKT_CSUM_EN
    exp_q.push_back({2'b11, cs});
`endif
  endtask

  task automatic push_bytes(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) pend.push_back(base + 8'(i) * step);
  endtask

  task automatic wait_hs(input int target);
    int cyc = 0;
    while (hs_cnt < target && cyc < 600) begin
      @(posedge i_clk);
      cyc++;
    end
  endtask

  task automatic run_packet(input vec_t v);
    int lat, cyc, nf;
    nf = nflits(v.n);
    @(posedge i_clk); #1;
    rmode = v.mode; rph = 0;
    rd_cnt = 0; hs_cnt = 0;
    i_dest = v.dest;
    build_exp(v.exp_head, v.n, v.base, v.step);
    push_bytes(v.n, v.base, v.step);
    @(posedge i_clk);
    lat = 0;
    @(negedge i_clk);
    while (!o_valid && lat < 100) begin
      lat++;
      @(negedge i_clk);
    end
    check("header_latency", lat, (v.n == 16) ? 1 : 16);
    cyc = 0;
    do begin
      @(posedge i_clk);
      cyc++;
    end while (hs_cnt < nf && cyc < 600);
    if (v.mode == 0) check("back_to_back_span", cyc, nf);
    check("flit_count", hs_cnt, nf);
    check("pop_count", rd_cnt, v.n);
    @(negedge i_clk);
    check("idle_after_pkt", o_busy, 1'b0);
    check("fifo_drained", fq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'h5, 16, 8'h00, 8'h01, 0, 10'h15F};
    vecs[1] = '{4'h3,  3, 8'hA1, 8'h01, 0, 10'h132};
    vecs[2] = '{4'h9, 16, 8'h40, 8'h01, 1, 10'h19F};
    vecs[3] = '{4'h1,  2, 8'h3C, 8'hD3, 0, 10'h111};
    vecs[4] = '{4'hC,  1, 8'h77, 8'h01, 2, 10'h1C0};
    vecs[5] = '{4'h7,  8, 8'h10, 8'h03, 1, 10'h177};

    #3;
    check("rst_valid", o_valid, 1'b0);
    check("rst_rd", o_fifo_rd, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_flit", o_flit, 10'h000);
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;

    for (int k = 0; k < 6; k++) run_packet(vecs[k]);

    // reset in the middle of BODY: link drops at once, unread bytes re-packetised
    @(posedge i_clk); #1;
    rmode = 0; rd_cnt = 0; hs_cnt = 0; i_dest = 4'hE;
    build_exp(10'h1EF, 16, 8'h80, 8'h01);
    push_bytes(16, 8'h80, 8'h01);
    begin
      int cyc = 0;
      while (rd_cnt < 3 && cyc < 100) begin @(posedge i_clk); cyc++; end
      check("reached_body", rd_cnt, 3);
    end
    #2 i_reset = 1'b1;
    #1;
    check("async_rst_valid", o_valid, 1'b0);
    check("async_rst_rd", o_fifo_rd, 1'b0);
    check("async_rst_busy", o_busy, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1 rd_cnt = 0; hs_cnt = 0;
    build_exp(10'h1EC, 13, 8'h83, 8'h01);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("idle_after_rst", o_busy, 1'b0);
    wait_hs(14);
    check("post_rst_flits", hs_cnt, nflits(13));
    check("post_rst_pops", rd_cnt, 13);

    // oversupply: bytes arriving mid-packet wait for the next packet
    repeat (2) @(posedge i_clk);
    #1 rd_cnt = 0; hs_cnt = 0; i_dest = 4'hA;
    build_exp(10'h1AF, 16, 8'h20, 8'h01);
    build_exp(10'h1A3, 4, 8'h30, 8'h01);
    push_bytes(16, 8'h20, 8'h01);
    begin
      int cyc = 0;
      while (rd_cnt < 4 && cyc < 100) begin @(posedge i_clk); cyc++; end
    end
    #1 push_bytes(4, 8'h30, 8'h01);
    wait_hs(nflits(16) + nflits(4));
    check("oversupply_flits", hs_cnt, nflits(16) + nflits(4));
    check("oversupply_pops", rd_cnt, 20);
    check("oversupply_sb_empty", exp_q.size(), 0);

    repeat (2) @(posedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
